// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding and requester ids.
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic ID_CPU = 1'b0;
    localparam logic ID_DMA = 1'b1;

endpackage

// File: rtl/arb_grant_select.sv
// Combinational winner pick between the CPU and DMA requesters.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise CPU has fixed priority.
module arb_grant_select
    import data_memory_arbiter_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic rr_ptr,
`endif
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_id    = ID_CPU;
`ifdef ARB_ROUND_ROBIN_EN
        // The pointer only matters on a tie; a lone requester always wins.
        if (cpu_req && dma_req) begin
            grant_id = rr_ptr;
        end else if (dma_req) begin
            grant_id = ID_DMA;
        end
`else
        if (!cpu_req && dma_req) begin
            grant_id = ID_DMA;
        end
`endif
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between CPU (port 0) and DMA (port 1), one access per 3 cycles.
// Optional macro ARB_ROUND_ROBIN_EN switches from fixed CPU priority to round-robin arbitration.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    // Handshake: a requester holds req with stable we/addr/wdata until its one-cycle ack;
    // inputs are sampled only in IDLE, so changes during ACCESS/RESP have no effect.
    state_t            state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              grant_valid;
    logic              grant_id;
`ifdef ARB_ROUND_ROBIN_EN
    logic              rr_ptr_q, rr_ptr_d;
`endif

    arb_grant_select u_grant_select (
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
`ifdef ARB_ROUND_ROBIN_EN
        .rr_ptr      (rr_ptr_q),
`endif
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    id_d = grant_id;
                    if (grant_id == ID_DMA) begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_d = ~grant_id;
`endif
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Read data is captured on the edge that closes the access cycle.
                if (!we_q) begin
                    if (id_q == ID_DMA) dma_rdata_d = mem_read_data;
                    else                cpu_rdata_d = mem_read_data;
                end
                cpu_ack_d = (id_q == ID_CPU);
                dma_ack_d = (id_q == ID_DMA);
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            id_q        <= ID_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= ID_CPU;
`endif
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Memory bus is driven only during ACCESS, so both strobes can never be high together.
    assign mem_read       = (state_q == ST_ACCESS) && !we_q;
    assign mem_write      = (state_q == ST_ACCESS) && we_q;
    assign mem_address    = (state_q == ST_ACCESS) ? addr_q  : '0;
    assign mem_write_data = (state_q == ST_ACCESS) ? wdata_q : '0;
    assign cpu_ack        = cpu_ack_q;
    assign dma_ack        = dma_ack_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign dma_rdata      = dma_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: a transaction-level reference model predicts
// grant order, bus contents, ack timing and read data; honours ARB_ROUND_ROBIN_EN.
module tb_data_memory_arbiter;

    localparam bit P_CPU = 1'b0;
    localparam bit P_DMA = 1'b1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        cpu_ack, dma_ack, mem_read, mem_write;
    logic [31:0] cpu_rdata, dma_rdata, mem_address, mem_write_data, mem_read_data;

    data_memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Behavioural data_memory attached to the bus: async read, write on the clock edge.
    logic [31:0] env_mem [16] = '{default: 32'h0};
    int          wr_cnt = 0;
    assign mem_read_data = (mem_read === 1'b1) ? env_mem[mem_address[3:0]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (mem_write === 1'b1) begin
            env_mem[mem_address[3:0]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [16] = '{default: 32'h0};
    txn_t        cpu_q[$];
    txn_t        dma_q[$];
    logic [0:0]  exp_q[$];
    logic [0:0]  ack_port_log[$];
    int          ack_cyc_log[$];
    int          cyc = 0;
    int          free_at = 0;
    bit          has_exp = 0;
    logic        exp_port;
    int          exp_access_cyc, exp_ack_cyc;
    txn_t        exp_t;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_winner = P_DMA;
`endif
    int          checks = 0;
    int          passed = 0;

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    task automatic drive_inputs();
        cpu_req = (cpu_q.size() > 0);
        dma_req = (dma_q.size() > 0);
        if (cpu_req) begin
            cpu_we = cpu_q[0].we; cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
        end
        if (dma_req) begin
            dma_we = dma_q[0].we; dma_addr = dma_q[0].addr; dma_wdata = dma_q[0].wdata;
        end
    endtask

    task automatic arbitrate();
        logic c, d, w;
        c = (cpu_q.size() > 0);
        d = (dma_q.size() > 0);
        if (has_exp || cyc < free_at || !(c || d)) return;
        if (c && !d) w = P_CPU;
        else if (d && !c) w = P_DMA;
        else begin
`ifdef ARB_ROUND_ROBIN_EN
            w = (last_winner == P_CPU) ? P_DMA : P_CPU;
`else
            w = P_CPU;
`endif
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_winner = w;
`endif
        has_exp        = 1;
        exp_port       = w;
        exp_t          = (w == P_DMA) ? dma_q[0] : cpu_q[0];
        exp_access_cyc = cyc + 1;
        exp_ack_cyc    = cyc + 2;
        free_at        = cyc + 3;
    endtask

    // One clock: check this cycle's outputs against the model, then drive the next inputs.
    task automatic step();
        logic        exp_c, exp_d;
        logic [31:0] got;
        @(posedge clk);
        #1;
        cyc++;
        checks++;
        if (has_exp && cyc == exp_access_cyc) begin
            if ({mem_read, mem_write, mem_address, mem_write_data} !==
                {!exp_t.we, exp_t.we, exp_t.addr, exp_t.wdata})
                $display("FAIL access_bus cyc=%0d got rd=%0b wr=%0b addr=%h wd=%h exp rd=%0b wr=%0b addr=%h wd=%h",
                         cyc, mem_read, mem_write, mem_address, mem_write_data,
                         !exp_t.we, exp_t.we, exp_t.addr, exp_t.wdata);
            else passed++;
        end else begin
            if ({mem_read, mem_write} !== 2'b00)
                $display("FAIL strobes_quiet cyc=%0d got rd=%0b wr=%0b exp 0 0", cyc, mem_read, mem_write);
            else passed++;
        end
        exp_c = has_exp && cyc == exp_ack_cyc && exp_port == P_CPU;
        exp_d = has_exp && cyc == exp_ack_cyc && exp_port == P_DMA;
        checks++;
        if ({cpu_ack, dma_ack} !== {exp_c, exp_d})
            $display("FAIL acks cyc=%0d got cpu=%0b dma=%0b exp cpu=%0b dma=%0b", cyc, cpu_ack, dma_ack, exp_c, exp_d);
        else passed++;
        if (has_exp && cyc == exp_ack_cyc) begin
            if (!exp_t.we) begin
                got = (exp_port == P_DMA) ? dma_rdata : cpu_rdata;
                checks++;
                if (got !== ref_mem[exp_t.addr[3:0]])
                    $display("FAIL rdata port=%0d addr=%h got %h exp %h", exp_port, exp_t.addr, got, ref_mem[exp_t.addr[3:0]]);
                else passed++;
            end else begin
                ref_mem[exp_t.addr[3:0]] = exp_t.wdata;
            end
            if (exp_port == P_DMA) dma_q.delete(0);
            else                   cpu_q.delete(0);
            ack_port_log.push_back(exp_port);
            ack_cyc_log.push_back(cyc);
            has_exp = 0;
        end
        drive_inputs();
        arbitrate();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((cpu_q.size() > 0 || dma_q.size() > 0 || has_exp) && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (cpu_q.size() > 0 || dma_q.size() > 0 || has_exp)
            $display("FAIL drain_timeout got pending cpu=%0d dma=%0d exp all served within %0d cycles",
                     cpu_q.size(), dma_q.size(), max_cyc);
        else passed++;
    endtask

    // Reset is asserted for the rest of the current cycle; returns in the first post-reset cycle.
    task automatic apply_reset();
        reset = 1'b1;
        cpu_q.delete();
        dma_q.delete();
        has_exp = 0;
        drive_inputs();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        free_at = cyc;
`ifdef ARB_ROUND_ROBIN_EN
        last_winner = P_DMA;
`endif
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cpu_ack, dma_ack, mem_read, mem_write, mem_address, mem_write_data, cpu_rdata, dma_rdata} !== '0)
            $display("FAIL reset_values got ack=%0b%0b rd=%0b wr=%0b addr=%h wd=%h crd=%h drd=%h exp all 0",
                     cpu_ack, dma_ack, mem_read, mem_write, mem_address, mem_write_data, cpu_rdata, dma_rdata);
        else passed++;
    endtask

    task automatic test_cpu_write();
        int req_cyc, w0;
        w0 = wr_cnt;
        cpu_q.push_back(mk(1'b1, 32'd5, 32'd7));
        req_cyc = cyc + 1;
        drain(10);
        checks++;
        if (ack_port_log[$] !== P_CPU || ack_cyc_log[$] - req_cyc != 2)
            $display("FAIL write_latency got port=%0d lat=%0d exp port=0 lat=2", ack_port_log[$], ack_cyc_log[$] - req_cyc);
        else passed++;
        checks++;
        if (wr_cnt - w0 != 1) $display("FAIL write_count got %0d exp 1", wr_cnt - w0);
        else passed++;
    endtask

    task automatic test_cpu_read();
        cpu_q.push_back(mk(1'b0, 32'd5, 32'h0));
        drain(10);
        checks++;
        if (cpu_rdata !== 32'd7) $display("FAIL cpu_read_5 got %h exp %h", cpu_rdata, 32'd7);
        else passed++;
    endtask

    task automatic test_simultaneous();
        int base;
        apply_reset();
        base = ack_port_log.size();
        cpu_q.push_back(mk(1'b1, 32'd8, 32'h11));
        dma_q.push_back(mk(1'b1, 32'd9, 32'h22));
        drain(20);
        checks++;
        if (ack_port_log.size() != base + 2)
            $display("FAIL tie_ack_count got %0d exp 2", ack_port_log.size() - base);
        else if (ack_port_log[base] !== P_CPU || ack_port_log[base+1] !== P_DMA ||
                 ack_cyc_log[base+1] - ack_cyc_log[base] != 3)
            $display("FAIL tie_order got %0d,%0d gap=%0d exp 0,1 gap=3",
                     ack_port_log[base], ack_port_log[base+1], ack_cyc_log[base+1] - ack_cyc_log[base]);
        else passed++;
        cpu_q.push_back(mk(1'b0, 32'd8, 32'h0));
        dma_q.push_back(mk(1'b0, 32'd9, 32'h0));
        drain(20);
        checks++;
        if (cpu_rdata !== 32'h11 || dma_rdata !== 32'h22)
            $display("FAIL tie_readback got %h %h exp 11 22", cpu_rdata, dma_rdata);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int base;
        apply_reset();
        base = ack_port_log.size();
        for (int i = 0; i < 3; i++) begin
            cpu_q.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)), $urandom));
            dma_q.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)), $urandom));
        end
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_q.push_back(1'(i % 2));
`else
            exp_q.push_back(1'(i >= 3));
`endif
        end
        drain(40);
        checks++;
        if (ack_port_log.size() != base + 6) begin
            $display("FAIL stream_count got %0d exp 6", ack_port_log.size() - base);
        end else begin
            bit ok = 1;
            for (int i = 0; i < 6; i++) begin
                if (ack_port_log[base+i] !== exp_q[i]) begin
                    $display("FAIL stream_order idx=%0d got %0d exp %0d", i, ack_port_log[base+i], exp_q[i]);
                    ok = 0;
                end
            end
            if (ok) passed++;
        end
    endtask

    task automatic test_reset_mid_access();
        int n = 0;
        int base;
        dma_q.push_back(mk(1'b0, 32'd9, 32'h0));
        while (!(has_exp && exp_port == P_DMA && cyc == exp_access_cyc) && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (!(has_exp && cyc == exp_access_cyc)) $display("FAIL reach_access got no DMA access within 10 cycles exp access");
        else passed++;
        base = ack_port_log.size();
        apply_reset();
        checks++;
        if ({mem_read, mem_write, cpu_ack, dma_ack, dma_rdata} !== '0)
            $display("FAIL after_reset got rd=%0b wr=%0b ack=%0b%0b drd=%h exp all 0",
                     mem_read, mem_write, cpu_ack, dma_ack, dma_rdata);
        else passed++;
        repeat (3) step();
        checks++;
        if (ack_port_log.size() != base) $display("FAIL abandoned_ack got %0d acks exp 0", ack_port_log.size() - base);
        else passed++;
        dma_q.push_back(mk(1'b0, 32'd9, 32'h0));
        drain(10);
        checks++;
        if (dma_rdata !== 32'h22 || ack_port_log.size() != base + 1)
            $display("FAIL reissued_read got %h acks=%0d exp 22 acks=1", dma_rdata, ack_port_log.size() - base);
        else passed++;
    endtask

    task automatic test_idle();
        int a0, w0;
        a0 = ack_port_log.size();
        w0 = wr_cnt;
        repeat (10) step();
        checks++;
        if (ack_port_log.size() != a0 || wr_cnt != w0)
            $display("FAIL idle_bus got acks=%0d writes=%0d exp 0 0", ack_port_log.size() - a0, wr_cnt - w0);
        else passed++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 60; r++) begin
            if (cpu_q.size() == 0 && $urandom_range(0, 1) == 1)
                cpu_q.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom));
            if (dma_q.size() == 0 && $urandom_range(0, 1) == 1)
                dma_q.push_back(mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom));
            repeat ($urandom_range(1, 4)) step();
        end
        drain(40);
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_access();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
